// File: rtl/food_place_ctrl.sv
// food_place_ctrl: steps the food generator, screens each candidate against the snake body and publishes a free cell.
// Optional FOOD_SCAN_FALLBACK_EN: after MAX_TRIES generator collisions, linearly scan the grid for a free cell.
module food_place_ctrl #(
    parameter int COORD_W   = 4,
    parameter int MAX_TRIES = 9,
    parameter int GEN_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               eaten,
    output logic               gen_adv,
    input  logic [COORD_W-1:0] gen_x,
    input  logic [COORD_W-1:0] gen_y,
    output logic               occ_req,
    output logic [COORD_W-1:0] occ_x,
    output logic [COORD_W-1:0] occ_y,
    input  logic               occ_ack,
    input  logic               occ_hit,
    output logic [COORD_W-1:0] food_x,
    output logic [COORD_W-1:0] food_y,
    output logic               food_valid,
    output logic               busy,
    output logic               fail
);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int LAT_W = (GEN_LAT > 1) ? $clog2(GEN_LAT) : 1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ADV,
        WAIT_GEN,
        QUERY,
        WAIT_ACK,
        COMMIT
`ifdef FOOD_SCAN_FALLBACK_EN
        , SCAN
`endif
    } state_t;

    state_t           state_reg;
    logic [TRY_W-1:0] try_cnt_reg;
    logic [LAT_W-1:0] lat_cnt_reg;
    logic [TRY_W-1:0] try_cnt_next;

    assign try_cnt_next = try_cnt_reg + TRY_W'(1);

`ifdef FOOD_SCAN_FALLBACK_EN
    logic scan_reg;
    logic scan_last;

    assign scan_last = (occ_x == '1) && (occ_y == '1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= INIT;
            try_cnt_reg <= '0;
            lat_cnt_reg <= '0;
            gen_adv     <= 1'b0;
            occ_req     <= 1'b0;
            occ_x       <= '0;
            occ_y       <= '0;
            food_x      <= '0;
            food_y      <= '0;
            food_valid  <= 1'b0;
            busy        <= 1'b0;
            fail        <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
            scan_reg    <= 1'b0;
`endif
        end else begin
            gen_adv <= 1'b0;
            case (state_reg)
                // The first food uses whatever the generator shows out of reset.
                INIT: begin
                    try_cnt_reg <= '0;
                    lat_cnt_reg <= '0;
                    busy        <= 1'b1;
                    state_reg   <= WAIT_GEN;
                end
                IDLE: begin
                    if (eaten) begin
                        food_valid  <= 1'b0;
                        busy        <= 1'b1;
                        try_cnt_reg <= '0;
                        gen_adv     <= 1'b1;
                        state_reg   <= ADV;
                    end
                end
                ADV: begin
                    lat_cnt_reg <= '0;
                    state_reg   <= WAIT_GEN;
                end
                WAIT_GEN: begin
                    if (lat_cnt_reg == LAT_W'(GEN_LAT - 1)) begin
                        occ_x     <= gen_x;
                        occ_y     <= gen_y;
                        state_reg <= QUERY;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
                    end
                end
                QUERY: begin
                    occ_req   <= 1'b1;
                    state_reg <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (occ_ack) begin
                        occ_req <= 1'b0;
                        if (!occ_hit) begin
                            state_reg <= COMMIT;
`ifdef FOOD_SCAN_FALLBACK_EN
                        end else if (scan_reg) begin
                            if (scan_last) begin
                                scan_reg   <= 1'b0;
                                fail       <= 1'b1;
                                food_valid <= 1'b0;
                                busy       <= 1'b0;
                                state_reg  <= IDLE;
                            end else begin
                                // x runs fastest across the grid
                                if (occ_x == '1) begin
                                    occ_x <= '0;
                                    occ_y <= occ_y + COORD_W'(1);
                                end else begin
                                    occ_x <= occ_x + COORD_W'(1);
                                end
                                state_reg <= SCAN;
                            end
`endif
                        end else if (try_cnt_next == TRY_W'(MAX_TRIES)) begin
                            try_cnt_reg <= try_cnt_next;
`ifdef FOOD_SCAN_FALLBACK_EN
                            scan_reg    <= 1'b1;
                            occ_x       <= '0;
                            occ_y       <= '0;
                            state_reg   <= SCAN;
`else
                            fail        <= 1'b1;
                            food_valid  <= 1'b0;
                            busy        <= 1'b0;
                            state_reg   <= IDLE;
`endif
                        end else begin
                            try_cnt_reg <= try_cnt_next;
                            gen_adv     <= 1'b1;
                            state_reg   <= ADV;
                        end
                    end
                end
                COMMIT: begin
                    food_x     <= occ_x;
                    food_y     <= occ_y;
                    food_valid <= 1'b1;
                    busy       <= 1'b0;
                    fail       <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
                    scan_reg   <= 1'b0;
`endif
                    state_reg  <= IDLE;
                end
`ifdef FOOD_SCAN_FALLBACK_EN
                SCAN: begin
                    occ_req   <= 1'b1;
                    state_reg <= WAIT_ACK;
                end
`endif
                default: state_reg <= INIT;
            endcase
        end
    end
endmodule
